// File: rtl/tbm_fifo_pkg.sv
// Shared constants, helpers and types for the token FIFO.
package tbm_fifo_pkg;

    localparam int unsigned TOKEN_BIT  = 0;
    localparam int unsigned STAT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/tbm_fifo_ram.sv
// Simple dual-port payload store: synchronous write, asynchronous read, no reset.
module tbm_fifo_ram
    import tbm_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [ptr_width(DEPTH)-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [ptr_width(DEPTH)-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]          rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tbm_token_fifo.sv
// Show-ahead FIFO with per-entry token bits that can be cleared in one cycle.
// Optional statistics counters enabled by defining TBM_TOKEN_FIFO_STATS_EN.
module tbm_token_fifo
    import tbm_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 36,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AFULL_LEVEL = DEPTH - 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sync,
    input  logic                       write,
    input  logic                       read,
    input  logic                       clear,
    input  logic                       clear_token,
    input  logic [DATA_WIDTH:0]        din,
    output logic [DATA_WIDTH:0]        dout,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     size,
    output logic                       overflow,
    output logic                       underflow,
    output logic [STAT_WIDTH-1:0]      stat_dropped,
    output logic [$clog2(DEPTH):0]     stat_peak
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned SW = PW + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [SW-1:0]         size_q;
    logic [SW-1:0]         size_nxt;
    logic [DEPTH-1:0]      tokens;
    logic [DEPTH-1:0]      tokens_nxt;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  do_clear;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  wr_rej;
    logic                  rd_rej;
    logic [DATA_WIDTH-1:0] ram_rdata;
    fifo_op_e              op;

    assign empty       = (size_q == '0);
    assign full        = (size_q == SW'(DEPTH));
    assign almost_full = (size_q >= SW'(AFULL_LEVEL));
    assign size        = size_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

    // clear wins over everything, so it masks every other acceptance term
    assign do_clear = sync & clear;
    assign rd_acc   = sync & ~clear & read & ~empty;
    assign rd_rej   = sync & ~clear & read & empty;
    assign wr_acc   = sync & ~clear & write & (~full | rd_acc);
    assign wr_rej   = sync & ~clear & write & full & ~rd_acc;

    always_comb begin
        op = fifo_op_e'({wr_acc, rd_acc});
    end

    always_comb begin
        size_nxt = size_q;
        unique case (op)
            OP_PUSH: size_nxt = size_q + SW'(1);
            OP_POP:  size_nxt = size_q - SW'(1);
            default: size_nxt = size_q;
        endcase
    end

    always_comb begin
        tokens_nxt = tokens;
        if (sync && clear_token) begin
            tokens_nxt = '0;
        end
        if (wr_acc) begin
            tokens_nxt[wr_ptr] = din[TOKEN_BIT];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            size_q <= '0;
            tokens <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (do_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            size_q <= '0;
            tokens <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            size_q <= size_nxt;
            tokens <= tokens_nxt;
            if (wr_rej) ovf_q <= 1'b1;
            if (rd_rej) unf_q <= 1'b1;
        end
    end

    tbm_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din[DATA_WIDTH:1]),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign dout = empty ? '0 : {ram_rdata, tokens[rd_ptr]};

`ifdef TBM_TOKEN_FIFO_STATS_EN
    logic [STAT_WIDTH-1:0] dropped_q;
    logic [SW-1:0]         peak_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropped_q <= '0;
            peak_q    <= '0;
        end else if (do_clear) begin
            dropped_q <= '0;
            peak_q    <= '0;
        end else begin
            if (wr_rej && (dropped_q != '1)) dropped_q <= dropped_q + STAT_WIDTH'(1);
            if (size_nxt > peak_q) peak_q <= size_nxt;
        end
    end

    assign stat_dropped = dropped_q;
    assign stat_peak    = peak_q;
`else
    assign stat_dropped = '0;
    assign stat_peak    = '0;
`endif

endmodule

// File: tb/tb_tbm_token_fifo.sv
// Directed, table-driven bench for tbm_token_fifo at default parameters.
module tb_tbm_token_fifo;

    localparam int unsigned DW = 36;
    localparam int unsigned DEPTH = 16;
`ifdef TBM_TOKEN_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sync = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic          clear = 1'b0;
    logic          clear_token = 1'b0;
    logic [DW:0]   din = '0;
    logic [DW:0]   dout;
    logic          empty, full, almost_full, overflow, underflow;
    logic [4:0]    size;
    logic [15:0]   stat_dropped;
    logic [4:0]    stat_peak;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    tbm_token_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (DEPTH - 4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sync         (sync),
        .write        (write),
        .read         (read),
        .clear        (clear),
        .clear_token  (clear_token),
        .din          (din),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .size         (size),
        .overflow     (overflow),
        .underflow    (underflow),
        .stat_dropped (stat_dropped),
        .stat_peak    (stat_peak)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s, w, r, c, ct;
        logic [DW:0] d;
        logic [DW:0] e_dout;
        int unsigned e_size;
        bit          e_empty;
        bit          e_unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit s, bit w, bit r, bit c, bit ct, logic [DW:0] d,
                                logic [DW:0] e_dout, int unsigned e_size, bit e_empty, bit e_unf);
        vec_t v;
        v.s = s; v.w = w; v.r = r; v.c = c; v.ct = ct; v.d = d;
        v.e_dout = e_dout; v.e_size = e_size; v.e_empty = e_empty; v.e_unf = e_unf;
        return v;
    endfunction

    function automatic logic [DW:0] ent(logic [DW-1:0] p, bit t);
        return {p, t};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock with the given inputs; returns #1 after the edge with inputs idle.
    task automatic drive(input bit s, input bit w, input bit r, input bit c, input bit ct,
                         input logic [DW:0] d);
        @(negedge clk);
        sync = s; write = w; read = r; clear = c; clear_token = ct; din = d;
        @(posedge clk);
        #1;
        sync = 1'b0; write = 1'b0; read = 1'b0; clear = 1'b0; clear_token = 1'b0; din = '0;
    endtask

    logic [DW:0] q[$];
    logic [DW:0] d;

    initial begin
        vecs.push_back(mk(1,1,0,0,0, ent(36'h5_0000_0001,1), ent(36'h5_0000_0001,1), 1, 0, 0));
        vecs.push_back(mk(0,1,1,1,1, ent(36'h0_0000_00FF,0), ent(36'h5_0000_0001,1), 1, 0, 0));
        vecs.push_back(mk(1,1,0,0,0, ent(36'h0_0000_0002,1), ent(36'h5_0000_0001,1), 2, 0, 0));
        vecs.push_back(mk(1,1,0,0,0, ent(36'h0_0000_0003,1), ent(36'h5_0000_0001,1), 3, 0, 0));
        vecs.push_back(mk(1,1,0,0,1, ent(36'h0_0000_0004,1), ent(36'h5_0000_0001,0), 4, 0, 0));
        vecs.push_back(mk(1,0,1,0,0, '0,                     ent(36'h0_0000_0002,0), 3, 0, 0));
        vecs.push_back(mk(1,0,1,0,0, '0,                     ent(36'h0_0000_0003,0), 2, 0, 0));
        vecs.push_back(mk(1,0,1,0,0, '0,                     ent(36'h0_0000_0004,1), 1, 0, 0));
        vecs.push_back(mk(1,0,1,0,0, '0,                     '0,                     0, 1, 0));
        vecs.push_back(mk(1,1,1,0,0, ent(36'hA_BCDE_F012,0), ent(36'hA_BCDE_F012,0), 1, 0, 1));
        vecs.push_back(mk(1,0,1,0,0, '0,                     '0,                     0, 1, 1));
        vecs.push_back(mk(1,0,1,0,0, '0,                     '0,                     0, 1, 1));
        vecs.push_back(mk(1,0,0,1,0, '0,                     '0,                     0, 1, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_afull", 64'(almost_full), 64'd0);
        chk("rst_size", 64'(size), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_unf", 64'(underflow), 64'd0);
        chk("rst_drop", 64'(stat_dropped), 64'd0);
        chk("rst_peak", 64'(stat_peak), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].s, vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].ct, vecs[i].d);
            chk($sformatf("v%0d_dout", i), 64'(dout), 64'(vecs[i].e_dout));
            chk($sformatf("v%0d_size", i), 64'(size), 64'(vecs[i].e_size));
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].e_empty));
            chk($sformatf("v%0d_unf", i), 64'(underflow), 64'(vecs[i].e_unf));
        end
        chk("clr_peak", 64'(stat_peak), 64'd0);

        // fill to full, overflow, then simultaneous read+write at full
        for (int k = 1; k <= 16; k++) begin
            drive(1,1,0,0,0, ent(DW'(k), k[0]));
            chk($sformatf("fill%0d_size", k), 64'(size), 64'(k));
            chk($sformatf("fill%0d_afull", k), 64'(almost_full), 64'(k >= 12));
            chk($sformatf("fill%0d_full", k), 64'(full), 64'(k == 16));
        end
        chk("fill_ovf_pre", 64'(overflow), 64'd0);
        drive(1,1,0,0,0, ent(36'hDEAD, 1));
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_size", 64'(size), 64'd16);
        chk("ovf_drop", 64'(stat_dropped), STATS ? 64'd1 : 64'd0);
        drive(1,1,1,0,0, ent(36'h77, 0));
        chk("full_rw_size", 64'(size), 64'd16);
        chk("full_rw_full", 64'(full), 64'd1);
        chk("full_rw_dout", 64'(dout), 64'(ent(DW'(2), 1'b0)));
        chk("full_rw_drop", 64'(stat_dropped), STATS ? 64'd1 : 64'd0);
        chk("full_peak", 64'(stat_peak), STATS ? 64'd16 : 64'd0);
        drive(1,0,0,1,0, '0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_drop", 64'(stat_dropped), 64'd0);
        chk("clr_size", 64'(size), 64'd0);

        // 40 write/read pairs across pointer wrap
        q.delete();
        for (int k = 0; k < 3; k++) begin
            d = ent(DW'(36'h9_0000_0000 + k), 1'b1);
            drive(1,1,0,0,0, d);
            q.push_back(d);
        end
        for (int k = 0; k < 40; k++) begin
            d = ent(DW'(36'h1_0000_0100 + k), k[0]);
            drive(1,1,1,0,0, d);
            void'(q.pop_front());
            q.push_back(d);
            chk($sformatf("wrap%0d_dout", k), 64'(dout), 64'(q[0]));
            if (size != 5'd3) chk($sformatf("wrap%0d_size", k), 64'(size), 64'd3);
        end
        chk("wrap_peak", 64'(stat_peak), STATS ? 64'd3 : 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain%0d_dout", k), 64'(dout), 64'(q[0]));
            drive(1,0,1,0,0, '0);
            void'(q.pop_front());
        end
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_dout", 64'(dout), 64'd0);

        // asynchronous reset mid-burst
        for (int k = 0; k < 7; k++) drive(1,1,0,0,0, ent(DW'(k + 50), 1'b1));
        chk("burst_size", 64'(size), 64'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_size", 64'(size), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_dout", 64'(dout), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, k[0], ~k[0], k[1], 1, ent(DW'(k + 200), 1'b1));
            chk($sformatf("nosync%0d_size", k), 64'(size), 64'd0);
            chk($sformatf("nosync%0d_empty", k), 64'(empty), 64'd1);
        end
        chk("nosync_unf", 64'(underflow), 64'd0);
        drive(1,1,0,0,0, ent(36'h3_1415_9265, 1'b0));
        chk("post_rst_head", 64'(dout), 64'(ent(36'h3_1415_9265, 1'b0)));
        chk("post_rst_size", 64'(size), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tbm_token_fifo.md
TBM_TOKEN_FIFO -- requirements
Module: tbm_token_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 36, payload width excluding token bit.
REQ-002 SHALL have parameter DEPTH, default 16, entry count, power of two, 4..256.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-4, almost_full threshold, 1..DEPTH.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 sync  input  1  clock enable; write, read, clear, clear_token act only when high.
REQ-007 write  input  1  push request.
REQ-008 read  input  1  pop request.
REQ-009 clear  input  1  synchronous flush.
REQ-010 clear_token  input  1  zero token bit of every stored entry.
REQ-011 din  input  DATA_WIDTH+1  {payload, token}; token is bit 0.
REQ-012 dout  output  DATA_WIDTH+1  head entry {payload, token}, show-ahead.
REQ-013 empty, full, almost_full  output  1 each  level flags.
REQ-014 size  output  $clog2(DEPTH)+1  fill count 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.
REQ-016 stat_dropped  output  16  rejected-write count; stat_peak  output  $clog2(DEPTH)+1  maximum size.

Function
REQ-017 An accepted write (sync, write, and !full or read accepted in the same cycle) SHALL store din at the tail.
REQ-018 An accepted read (sync, read, !empty) SHALL remove the head entry.
REQ-019 Full with simultaneous write and read SHALL accept both; size unchanged.
REQ-020 Empty with simultaneous write and read SHALL accept the write only; the read is an underflow.
REQ-021 dout SHALL show the head combinationally when !empty; a write to an empty FIFO SHALL appear on dout one clk after the write edge.
REQ-022 When empty, dout SHALL be all zeros.
REQ-023 size SHALL increment on write-only, decrement on read-only, hold otherwise; empty = (size==0), full = (size==DEPTH), almost_full = (size>=AFULL_LEVEL).
REQ-024 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 Token bits SHALL be held in a DEPTH-bit register vector beside the payload RAM so clear_token completes in one cycle.
REQ-026 clear_token with an accepted write SHALL zero all previously stored tokens and store the written entry's token as din[0].
REQ-027 clear SHALL have priority over all other inputs: pointers and size to 0, all tokens to 0, overflow and underflow to 0, and stats to 0.
REQ-028 write while full without an accepted read SHALL set overflow; read while empty SHALL set underflow; both flags hold until clear or reset.
REQ-029 Requests with sync low SHALL have no effect.

Reset
REQ-030 Reset SHALL force pointers, size, tokens, overflow, underflow, and stats to 0, so empty=1, full=0, almost_full=0, and dout=0.
REQ-031 Reset mid-operation SHALL discard all contents, with the next accepted write becoming the head.
REQ-032 Payload RAM contents SHALL not require reset.

Configuration
REQ-033 With macro TBM_TOKEN_FIFO_STATS_EN defined, stat_dropped SHALL count rejected writes, saturating at 0xFFFF.
REQ-034 With TBM_TOKEN_FIFO_STATS_EN defined, stat_peak SHALL track the maximum size since reset or clear.
REQ-035 Without TBM_TOKEN_FIFO_STATS_EN, the stat ports SHALL remain present, be driven constant 0, and use no counter logic.

Structure
REQ-036 Package tbm_fifo_pkg SHALL hold the token bit index constant, the stat counter width (16), and a ptr-width function, $clog2 of depth.
REQ-037 Payload storage SHALL be sub-module tbm_fifo_ram: simple dual-port, DEPTH x DATA_WIDTH, synchronous write, asynchronous read.

Verification
REQ-038 After reset, write 0x5_0000_0001 with token 1 -> next cycle dout=0x5_0000_0001 with token 1, size=1, empty=0.
REQ-039 Fill 16 entries at default parameters -> full=1, almost_full=1 from size 12; a 17th write sets overflow and stat_dropped=1; simultaneous read+write at full keeps size=16.
REQ-040 Store 3 entries with token=1, then clear_token together with a write with token=1 -> the first 3 read back token 0, the 4th reads back token 1.
REQ-041 Perform 40 write/read pairs at DEPTH=16 -> order is preserved across pointer wrap, and stat_peak equals the maximum size reached.
REQ-042 Read when empty -> underflow=1 and dout=0; then clear -> underflow=0, size=0, stats=0.
REQ-043 Assert reset mid-burst with 7 stored -> size=0 and empty=1 immediately; toggling write/read with sync=0 -> no state change.
